// File: rtl/safebox_ctrl.sv
// -----------------------------------------------------------------------------
// safebox_ctrl
//
// Password-lock controller for a 4-digit safe box. The controller takes
// single-cycle key pulses from the debounce stage and a 4-bit digit switch
// bank. It collects a 4-digit entry and compares it with the stored password.
// It opens the box, raises an alarm after repeated wrong attempts, and lets a
// new password be stored while the box is open.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   digit_in     digit switches, sampled only on an accepted enter pulse
//   enter_pulse  captures digit_in as the next digit
//   clear_pulse  discards the partial entry (aborts a password change)
//   lock_pulse   relocks the box
//   set_pulse    starts a password change while open
//   unlock       high in OPEN and SET
//   alarm        high in ALARM
//   err_cnt      consecutive wrong attempts (saturates at MAX_ERR)
//   digit_cnt    digits captured in the current entry (0..3)
//   state_o      LOCKED=0, CHECK=1, OPEN=2, SET=3, ALARM=4
//   pwd_updated  one-cycle pulse when a new password is stored
// -----------------------------------------------------------------------------
module safebox_ctrl #(
    parameter logic [15:0] DEFAULT_PWD  = 16'h1234,
    parameter int          MAX_ERR      = 3,
    parameter int          OPEN_CYCLES  = 50_000_000,
    parameter int          ALARM_CYCLES = 250_000_000,
    parameter int          TIMER_W      = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       enter_pulse,
    input  logic       clear_pulse,
    input  logic       lock_pulse,
    input  logic       set_pulse,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] err_cnt,
    output logic [2:0] digit_cnt,
    output logic [2:0] state_o,
    output logic       pwd_updated
);

    typedef enum logic [2:0] {
        S_LOCKED = 3'd0,
        S_CHECK  = 3'd1,
        S_OPEN   = 3'd2,
        S_SET    = 3'd3,
        S_ALARM  = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYCLES);
    localparam logic [TIMER_W-1:0] ALARM_LOAD = TIMER_W'(ALARM_CYCLES);
    localparam logic [2:0]         MAX_ERR_W  = 3'(MAX_ERR);

    state_t             state;
    logic [15:0]        entry;
    logic [15:0]        pwd;
    logic [TIMER_W-1:0] timer;

    // Only the highest-priority pulse of a cycle is acted on:
    // clear > lock > set > enter.
    logic clear_acc;
    logic lock_acc;
    logic set_acc;
    logic enter_acc;

    assign clear_acc = clear_pulse;
    assign lock_acc  = lock_pulse  & ~clear_pulse;
    assign set_acc   = set_pulse   & ~clear_pulse & ~lock_pulse;
    assign enter_acc = enter_pulse & ~clear_pulse & ~lock_pulse & ~set_pulse;

    logic [15:0] shifted;
    logic        last_digit;
    logic [2:0]  err_next;

    assign shifted    = {entry[11:0], digit_in};
    assign last_digit = (digit_cnt == 3'd3);
    assign err_next   = {1'b0, err_cnt} + 3'd1;

    assign state_o = state;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch sees the values from before this edge; mixing in blocking writes
    // would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOCKED;
            entry       <= '0;
            pwd         <= DEFAULT_PWD;
            timer       <= '0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            err_cnt     <= 2'd0;
            digit_cnt   <= 3'd0;
            pwd_updated <= 1'b0;
        end else begin
            pwd_updated <= 1'b0;

            case (state)
                S_LOCKED: begin
                    if (clear_acc) begin
                        entry     <= '0;
                        digit_cnt <= 3'd0;
                    end else if (enter_acc) begin
                        entry <= shifted;
                        if (last_digit) begin
                            digit_cnt <= 3'd0;
                            state     <= S_CHECK;
                        end else begin
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
                end

                S_CHECK: begin
                    entry     <= '0;
                    digit_cnt <= 3'd0;
                    if (entry == pwd) begin
                        state   <= S_OPEN;
                        err_cnt <= 2'd0;
                        timer   <= OPEN_LOAD;
                        unlock  <= 1'b1;
                    end else if (err_next >= MAX_ERR_W) begin
                        // >= rather than == keeps err_cnt saturated even if it
                        // ever sat at MAX_ERR on entry.
                        state   <= S_ALARM;
                        err_cnt <= MAX_ERR_W[1:0];
                        timer   <= ALARM_LOAD;
                        alarm   <= 1'b1;
                    end else begin
                        state   <= S_LOCKED;
                        err_cnt <= err_next[1:0];
                    end
                end

                S_OPEN: begin
                    if (lock_acc) begin
                        state  <= S_LOCKED;
                        timer  <= '0;
                        unlock <= 1'b0;
                    end else if (set_acc) begin
                        state     <= S_SET;
                        entry     <= '0;
                        digit_cnt <= 3'd0;
                    end else if (timer <= TIMER_W'(1)) begin
                        // Last open cycle: unlock stays high exactly OPEN_CYCLES.
                        state  <= S_LOCKED;
                        timer  <= '0;
                        unlock <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                S_SET: begin
                    // Timer is frozen here; the box cannot auto-relock mid-change.
                    if (clear_acc) begin
                        state     <= S_OPEN;
                        timer     <= OPEN_LOAD;
                        entry     <= '0;
                        digit_cnt <= 3'd0;
                    end else if (lock_acc) begin
                        state     <= S_LOCKED;
                        timer     <= '0;
                        unlock    <= 1'b0;
                        entry     <= '0;
                        digit_cnt <= 3'd0;
                    end else if (enter_acc) begin
                        if (last_digit) begin
                            pwd         <= shifted;
                            pwd_updated <= 1'b1;
                            state       <= S_OPEN;
                            timer       <= OPEN_LOAD;
                            entry       <= '0;
                            digit_cnt   <= 3'd0;
                        end else begin
                            entry     <= shifted;
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
                end

                S_ALARM: begin
                    if (timer <= TIMER_W'(1)) begin
                        state   <= S_LOCKED;
                        timer   <= '0;
                        alarm   <= 1'b0;
                        err_cnt <= 2'd0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                default: begin
                    state     <= S_LOCKED;
                    entry     <= '0;
                    timer     <= '0;
                    unlock    <= 1'b0;
                    alarm     <= 1'b0;
                    digit_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safebox_ctrl.sv
// -----------------------------------------------------------------------------
// tb_safebox_ctrl
//
// Directed self-checking bench for safebox_ctrl with short timer settings
// (OPEN_CYCLES=10, ALARM_CYCLES=20, MAX_ERR=3). Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_safebox_ctrl;

    localparam int OPEN_CYCLES  = 10;
    localparam int ALARM_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       enter_pulse, clear_pulse, lock_pulse, set_pulse;
    logic       unlock, alarm, pwd_updated;
    logic [1:0] err_cnt;
    logic [2:0] digit_cnt, state_o;

    int passed = 0;
    int total  = 0;

    safebox_ctrl #(
        .DEFAULT_PWD (16'h1234),
        .MAX_ERR     (3),
        .OPEN_CYCLES (OPEN_CYCLES),
        .ALARM_CYCLES(ALARM_CYCLES),
        .TIMER_W     (28)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digit_in),
        .enter_pulse(enter_pulse),
        .clear_pulse(clear_pulse),
        .lock_pulse (lock_pulse),
        .set_pulse  (set_pulse),
        .unlock     (unlock),
        .alarm      (alarm),
        .err_cnt    (err_cnt),
        .digit_cnt  (digit_cnt),
        .state_o    (state_o),
        .pwd_updated(pwd_updated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a set of pulses for exactly one clock, then sample just after the edge.
    task automatic press(input logic e, input logic c, input logic l, input logic s,
                         input logic [3:0] d);
        @(negedge clk);
        enter_pulse = e;
        clear_pulse = c;
        lock_pulse  = l;
        set_pulse   = s;
        digit_in    = d;
        @(posedge clk);
        #1;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        lock_pulse  = 1'b0;
        set_pulse   = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 1'b0, code[15-4*i -: 4]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_unlock"}, 32'(unlock), 32'd0);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_err"}, 32'(err_cnt), 32'd0);
        check({tag, "_dcnt"}, 32'(digit_cnt), 32'd0);
        check({tag, "_pwdupd"}, 32'(pwd_updated), 32'd0);
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        digit_in = 4'd0;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        lock_pulse = 1'b0;
        set_pulse = 1'b0;
        step();
        do_reset();
        check_reset_outputs("rst0");

        // 1. Correct password, then auto-relock after exactly OPEN_CYCLES.
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        check("t1_dcnt1", 32'(digit_cnt), 32'd1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
        check("t1_dcnt3", 32'(digit_cnt), 32'd3);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h4);
        check("t1_check_state", 32'(state_o), 32'd1);
        check("t1_check_dcnt", 32'(digit_cnt), 32'd0);
        check("t1_check_unlock", 32'(unlock), 32'd0);
        step();
        check("t1_open_state", 32'(state_o), 32'd2);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!unlock) break;
            cnt++;
            step();
        end
        check("t1_unlock_cycles", 32'(cnt), 32'(OPEN_CYCLES));
        check("t1_relock_state", 32'(state_o), 32'd0);

        // 2. Three wrong attempts -> alarm for ALARM_CYCLES, pulses ignored.
        enter_code(16'h1235);
        step();
        check("t2_err1", 32'(err_cnt), 32'd1);
        check("t2_err1_state", 32'(state_o), 32'd0);
        enter_code(16'h1235);
        step();
        check("t2_err2", 32'(err_cnt), 32'd2);
        enter_code(16'h1235);
        step();
        check("t2_alarm_state", 32'(state_o), 32'd4);
        check("t2_alarm_err", 32'(err_cnt), 32'd3);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!alarm) break;
            cnt++;
            case (i)
                1: press(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
                2: press(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
                3: press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
                4: press(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
                default: step();
            endcase
            if (i == 1) check("t2_alarm_ignore_enter", 32'(digit_cnt), 32'd0);
            if (i == 3) check("t2_alarm_ignore_lock", 32'(state_o), 32'd4);
        end
        check("t2_alarm_cycles", 32'(cnt), 32'(ALARM_CYCLES));
        check("t2_after_state", 32'(state_o), 32'd0);
        check("t2_after_err", 32'(err_cnt), 32'd0);

        // 3. Clear discards a partial entry; correct password clears err_cnt.
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
        press(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("t3_clear_dcnt", 32'(digit_cnt), 32'd0);
        enter_code(16'h1234);
        step();
        check("t3_unlock", 32'(unlock), 32'd1);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("t3_lock_state", 32'(state_o), 32'd0);
        check("t3_lock_unlock", 32'(unlock), 32'd0);
        enter_code(16'h4321);
        step();
        check("t3_wrong_err", 32'(err_cnt), 32'd1);
        enter_code(16'h1234);
        step();
        check("t3_right_state", 32'(state_o), 32'd2);
        check("t3_right_err", 32'(err_cnt), 32'd0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

        // 4. Change password to ABCD.
        enter_code(16'h1234);
        step();
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("t4_set_state", 32'(state_o), 32'd3);
        check("t4_set_unlock", 32'(unlock), 32'd1);
        enter_code(16'hABCD);
        check("t4_upd_pulse", 32'(pwd_updated), 32'd1);
        check("t4_upd_state", 32'(state_o), 32'd2);
        step();
        check("t4_upd_pulse_end", 32'(pwd_updated), 32'd0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("t4_locked", 32'(state_o), 32'd0);
        enter_code(16'h1234);
        step();
        check("t4_old_rejected", 32'(state_o), 32'd0);
        check("t4_old_err", 32'(err_cnt), 32'd1);
        enter_code(16'hABCD);
        step();
        check("t4_new_unlocks", 32'(state_o), 32'd2);
        check("t4_new_err", 32'(err_cnt), 32'd0);

        // 5. Abort a password change with lock; clear beats enter.
        do_reset();
        enter_code(16'h1234);
        step();
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
        check("t5_set_dcnt", 32'(digit_cnt), 32'd2);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("t5_abort_state", 32'(state_o), 32'd0);
        check("t5_abort_dcnt", 32'(digit_cnt), 32'd0);
        enter_code(16'h1234);
        step();
        check("t5_pwd_kept", 32'(state_o), 32'd2);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
        check("t5_one_digit", 32'(digit_cnt), 32'd1);
        press(1'b1, 1'b1, 1'b0, 1'b0, 4'h6);
        check("t5_clear_wins", 32'(digit_cnt), 32'd0);

        // 6. Reset in SET (after a stored change) and in ALARM.
        enter_code(16'h1234);
        step();
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        enter_code(16'h5678);
        check("t6_changed", 32'(pwd_updated), 32'd1);
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 4'h7);
        check("t6_in_set", 32'(state_o), 32'd3);
        do_reset();
        check_reset_outputs("t6_rst_set");
        enter_code(16'h1234);
        step();
        check("t6_default_pwd", 32'(state_o), 32'd2);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h0000);
            step();
        end
        check("t6_in_alarm", 32'(alarm), 32'd1);
        do_reset();
        check_reset_outputs("t6_rst_alarm");
        enter_code(16'h1234);
        step();
        check("t6_alarm_rst_unlock", 32'(unlock), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
